ram_port_arbiter: RTL and testbench

Shares the single external RAM controller command port between four requesters: camera frame writes, display (VGA) reads, HDR exposure reads and tone-mapped HDR writes. Single-cycle request pulses are latched one-deep per requester and granted by fixed priority with a starvation override. Commands are issued to the controller with a valid/ready handshake. In-order read data is routed back to the issuing reader through a tag FIFO. The block sits between the capture, HDR and display pipelines and the memory controller, and replaces the shared `ram_busy` signal with per-requester busy outputs.

---
 rtl/ram_port_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Arbitrates the external RAM controller command port between camera write, VGA read,
// HDR read and HDR write requesters; routes in-order read returns via a tag FIFO.

module ram_req_slot #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              clear,
  output logic              pending,
  output logic [ADDR_W-1:0] slot_address,
  output logic [DATA_W-1:0] slot_data,
  output logic              drop
);
  // A pulse into an occupied slot is lost, even in the cycle it is being cleared.
  assign drop = req && pending;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending      <= 1'b0;
      slot_address <= '0;
      slot_data    <= '0;
    end else begin
      if (clear) pending <= 1'b0;
      if (req && !pending) begin
        pending      <= 1'b1;
        slot_address <= address;
        slot_data    <= data;
      end
    end
  end
endmodule

module ram_port_arbiter #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 256,
  parameter int TAG_DEPTH  = 8,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cam_wr_req,
  input  logic [ADDR_W-1:0] cam_wr_address,
  input  logic [DATA_W-1:0] cam_wr_data,
  output logic              cam_busy,
  input  logic              vga_rd_req,
  input  logic [ADDR_W-1:0] vga_rd_address,
  output logic              vga_busy,
  output logic [DATA_W-1:0] vga_rd_data,
  output logic              vga_rd_valid,
  input  logic              hdr_rd_req,
  input  logic [ADDR_W-1:0] hdr_rd_address,
  output logic              hdr_rd_busy,
  output logic [DATA_W-1:0] hdr_rd_data,
  output logic              hdr_rd_valid,
  input  logic              hdr_wr_req,
  input  logic [ADDR_W-1:0] hdr_wr_address,
  input  logic [DATA_W-1:0] hdr_wr_data,
  output logic              hdr_wr_busy,
  output logic              mem_cmd_valid,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_address,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_cmd_ready,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_valid,
  output logic [1:0]        arb_error
);
  localparam int NUM_REQ = 4;
  localparam int PTR_W   = $clog2(TAG_DEPTH);
  localparam int SW      = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [1:0] CAM = 2'd0, VGA = 2'd1, HRD = 2'd2, HWR = 2'd3;
  localparam logic [NUM_REQ-1:0] IS_WR = 4'b1001;

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
  } cmd_t;

  state_t state;
  logic [1:0]    win;
  logic [SW-1:0] starve_cnt;

  logic [NUM_REQ-1:0]             req, pending, drop, clear, elig;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr, slot_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data, slot_data;

  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       tag_cnt;
  logic tag_full, tag_empty, push, pop, accept, starved, grant_any;
  logic [1:0] grant_idx;
  cmd_t grant_cmd;

  assign req      = {hdr_wr_req, hdr_rd_req, vga_rd_req, cam_wr_req};
  assign req_addr = {hdr_wr_address, hdr_rd_address, vga_rd_address, cam_wr_address};
  assign req_data = {hdr_wr_data, {DATA_W{1'b0}}, {DATA_W{1'b0}}, cam_wr_data};

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
      ram_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req[i]),
        .address      (req_addr[i]),
        .data         (req_data[i]),
        .clear        (clear[i]),
        .pending      (pending[i]),
        .slot_address (slot_addr[i]),
        .slot_data    (slot_data[i]),
        .drop         (drop[i])
      );
    end
  endgenerate

  assign cam_busy    = pending[CAM];
  assign vga_busy    = pending[VGA];
  assign hdr_rd_busy = pending[HRD];
  assign hdr_wr_busy = pending[HWR];

  // Depth is a power of two, so the count MSB alone marks full.
  assign tag_full  = tag_cnt[PTR_W];
  assign tag_empty = (tag_cnt == '0);

  assign accept = (state == ISSUE) && mem_cmd_valid && mem_cmd_ready;
  assign clear  = accept ? (NUM_REQ'(1) << win) : '0;
  assign push   = accept && !mem_cmd_we;
  assign pop    = mem_rd_valid && !tag_empty;

  always_comb begin
    elig      = pending & (IS_WR | {NUM_REQ{~tag_full}});
    starved   = pending[HWR] && (starve_cnt >= STARVE_LIM);
    grant_any = |elig;
    grant_idx = CAM;
    if (starved)        grant_idx = HWR;
    else if (elig[CAM]) grant_idx = CAM;
    else if (elig[VGA]) grant_idx = VGA;
    else if (elig[HRD]) grant_idx = HRD;
    else                grant_idx = HWR;
    grant_cmd.we      = IS_WR[grant_idx];
    grant_cmd.address = slot_addr[grant_idx];
    grant_cmd.data    = slot_data[grant_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      win             <= CAM;
      starve_cnt      <= '0;
      mem_cmd_valid   <= 1'b0;
      mem_cmd_we      <= 1'b0;
      mem_cmd_address <= '0;
      mem_wr_data     <= '0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          mem_cmd_valid   <= 1'b1;
          mem_cmd_we      <= grant_cmd.we;
          mem_cmd_address <= grant_cmd.address;
          mem_wr_data     <= grant_cmd.data;
          win             <= grant_idx;
          state           <= ISSUE;
        end
        ISSUE: if (accept) begin
          mem_cmd_valid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Counts grants that hdr_wr loses while it waits.
      if (!pending[HWR])
        starve_cnt <= '0;
      else if (state == IDLE && grant_any)
        starve_cnt <= (grant_idx == HWR) ? '0 : starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_mem      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      tag_cnt      <= '0;
      vga_rd_valid <= 1'b0;
      hdr_rd_valid <= 1'b0;
      vga_rd_data  <= '0;
      hdr_rd_data  <= '0;
      arb_error    <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= (win == HRD);
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
      vga_rd_valid <= pop && !tag_mem[rd_ptr];
      hdr_rd_valid <= pop &&  tag_mem[rd_ptr];
      if (pop && !tag_mem[rd_ptr]) vga_rd_data <= mem_rd_data;
      if (pop &&  tag_mem[rd_ptr]) hdr_rd_data <= mem_rd_data;
      arb_error <= arb_error | {mem_rd_valid && tag_empty, |drop};
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed checks of ram_port_arbiter against a transaction-level model.

module tb_ram_port_arbiter;
  localparam int AW = 25, DW = 256, TD = 8, SM = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic cam_wr_req = 0, vga_rd_req = 0, hdr_rd_req = 0, hdr_wr_req = 0;
  logic [AW-1:0] cam_wr_address = '0, vga_rd_address = '0, hdr_rd_address = '0, hdr_wr_address = '0;
  logic [DW-1:0] cam_wr_data = '0, hdr_wr_data = '0, mem_rd_data = '0;
  logic mem_cmd_ready = 1'b0, mem_rd_valid = 1'b0;
  logic cam_busy, vga_busy, hdr_rd_busy, hdr_wr_busy;
  logic vga_rd_valid, hdr_rd_valid, mem_cmd_valid, mem_cmd_we;
  logic [DW-1:0] vga_rd_data, hdr_rd_data, mem_wr_data;
  logic [AW-1:0] mem_cmd_address;
  logic [1:0] arb_error;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(TD), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .cam_wr_req(cam_wr_req), .cam_wr_address(cam_wr_address), .cam_wr_data(cam_wr_data),
    .cam_busy(cam_busy),
    .vga_rd_req(vga_rd_req), .vga_rd_address(vga_rd_address), .vga_busy(vga_busy),
    .vga_rd_data(vga_rd_data), .vga_rd_valid(vga_rd_valid),
    .hdr_rd_req(hdr_rd_req), .hdr_rd_address(hdr_rd_address), .hdr_rd_busy(hdr_rd_busy),
    .hdr_rd_data(hdr_rd_data), .hdr_rd_valid(hdr_rd_valid),
    .hdr_wr_req(hdr_wr_req), .hdr_wr_address(hdr_wr_address), .hdr_wr_data(hdr_wr_data),
    .hdr_wr_busy(hdr_wr_busy),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_we(mem_cmd_we), .mem_cmd_address(mem_cmd_address),
    .mem_wr_data(mem_wr_data), .mem_cmd_ready(mem_cmd_ready),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .arb_error(arb_error)
  );

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: requester index 0 cam, 1 vga, 2 hdr_rd, 3 hdr_wr.
  bit            m_pend[4];
  logic [AW-1:0] m_addr[4];
  logic [DW-1:0] m_data[4];
  bit            m_cv, m_we, m_vv, m_hv;
  logic [AW-1:0] m_ca;
  logic [DW-1:0] m_cd, m_vd, m_hd;
  int            m_win, m_starve;
  bit            tagq[$];
  bit [1:0]      m_err;

  task automatic model_step();
    bit req[4];
    logic [AW-1:0] a[4];
    logic [DW-1:0] d[4];
    bit pend_o[4];
    bit full, acc, t;
    int w;
    req[0] = cam_wr_req; req[1] = vga_rd_req; req[2] = hdr_rd_req; req[3] = hdr_wr_req;
    a[0] = cam_wr_address; a[1] = vga_rd_address; a[2] = hdr_rd_address; a[3] = hdr_wr_address;
    d[0] = cam_wr_data; d[1] = '0; d[2] = '0; d[3] = hdr_wr_data;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_addr[i] = '0; m_data[i] = '0; end
      m_cv = 0; m_we = 0; m_ca = '0; m_cd = '0; m_win = 0; m_starve = 0;
      m_vv = 0; m_hv = 0; m_vd = '0; m_hd = '0; m_err = '0;
      tagq.delete();
      return;
    end
    pend_o = m_pend;
    full = (tagq.size() >= TD);
    acc = m_cv && mem_cmd_ready;
    m_vv = 0; m_hv = 0;
    if (mem_rd_valid) begin
      if (tagq.size() == 0) m_err[1] = 1;
      else begin
        t = tagq.pop_front();
        if (t) begin m_hv = 1; m_hd = mem_rd_data; end
        else   begin m_vv = 1; m_vd = mem_rd_data; end
      end
    end
    w = -1;
    if (!m_cv) begin
      if (pend_o[3] && m_starve >= SM) w = 3;
      else for (int i = 0; i < 4; i++)
        if (w < 0 && pend_o[i] && (i == 0 || i == 3 || !full)) w = i;
    end
    if (!pend_o[3]) m_starve = 0;
    else if (w >= 0) m_starve = (w == 3) ? 0 : m_starve + 1;
    if (w >= 0) begin
      m_cv = 1; m_win = w; m_we = (w == 0 || w == 3); m_ca = m_addr[w]; m_cd = m_data[w];
    end else if (acc) begin
      m_cv = 0;
      if (m_win == 1 || m_win == 2) tagq.push_back(m_win == 2);
      m_pend[m_win] = 0;
    end
    for (int i = 0; i < 4; i++)
      if (req[i]) begin
        if (pend_o[i]) m_err[0] = 1;
        else begin m_pend[i] = 1; m_addr[i] = a[i]; m_data[i] = d[i]; end
      end
  endtask

  task automatic compare_all();
    check("busy", {hdr_wr_busy, hdr_rd_busy, vga_busy, cam_busy}, {m_pend[3], m_pend[2], m_pend[1], m_pend[0]});
    check("cmd_valid", mem_cmd_valid, m_cv);
    check("cmd_we", mem_cmd_we, m_we);
    check("cmd_addr", mem_cmd_address, m_ca);
    check("wr_data", mem_wr_data, m_cd);
    check("vga_valid", vga_rd_valid, m_vv);
    check("vga_data", vga_rd_data, m_vd);
    check("hdr_valid", hdr_rd_valid, m_hv);
    check("hdr_data", hdr_rd_data, m_hd);
    check("arb_error", arb_error, m_err);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    cam_wr_req = 0; vga_rd_req = 0; hdr_rd_req = 0; hdr_wr_req = 0; mem_rd_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; cycle(); cycle(); rst_n = 1;
  endtask

  function automatic logic [DW-1:0] rnd_d();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    int vfirst, vcnt, grants, found, k;
    bit wr_seen, rd_seen;
    logic [AW-1:0] aq[$];
    int iq[$];
    logic [DW-1:0] rd_words[3];

    do_reset();

    // single camera write
    mem_cmd_ready = 1;
    cam_wr_req = 1; cam_wr_address = 25'h96000; cam_wr_data = rnd_d();
    vfirst = 0; vcnt = 0;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (mem_cmd_valid) begin
        vcnt++;
        if (vfirst == 0) vfirst = i;
        check("cam_we", mem_cmd_we, 1);
        check("cam_addr", mem_cmd_address, 25'h96000);
      end
    end
    check("cam_lag", vfirst, 2);
    check("cam_vcnt", vcnt, 1);

    // simultaneous requests
    do_reset(); mem_cmd_ready = 1;
    cam_wr_req = 1; cam_wr_address = 1; vga_rd_req = 1; vga_rd_address = 2;
    hdr_rd_req = 1; hdr_rd_address = 3; hdr_wr_req = 1; hdr_wr_address = 4;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (mem_cmd_valid) begin aq.push_back(mem_cmd_address); iq.push_back(i); end
    end
    check("sim_count", aq.size(), 4);
    if (aq.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check($sformatf("sim_order%0d", i), aq[i], i + 1);
        if (i > 0) check($sformatf("sim_gap%0d", i), iq[i] - iq[i-1], 2);
      end

    // starvation: cam and vga alternate, hdr_wr waits
    do_reset(); mem_cmd_ready = 1;
    cam_wr_address = 25'h100; vga_rd_address = 25'h200; hdr_wr_address = 25'h300;
    cam_wr_req = 1; vga_rd_req = 1; hdr_wr_req = 1;
    grants = 0; found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      cycle();
      if (mem_cmd_valid) begin
        if (mem_cmd_address == 25'h300) begin
          found = 1;
          check("starve_cnt_clr", dut.starve_cnt, 0);
        end else grants++;
      end
      if (!m_pend[0]) cam_wr_req = 1;
      if (!m_pend[1]) vga_rd_req = 1;
      if (tagq.size() > 0) begin mem_rd_valid = 1; mem_rd_data = rnd_d(); end
    end
    check("starve_found", found, 1);
    check("starve_grants", grants, 16);
    for (int i = 0; i < 6; i++) begin
      if (tagq.size() > 0) begin mem_rd_valid = 1; mem_rd_data = rnd_d(); end
      cycle();
    end

    // read routing vga, hdr, vga
    do_reset(); mem_cmd_ready = 1;
    for (int r = 0; r < 3; r++) begin
      if (r == 1) begin hdr_rd_req = 1; hdr_rd_address = 25'h0B0; end
      else begin vga_rd_req = 1; vga_rd_address = AW'(25'h0A0 + r); end
      repeat (3) cycle();
    end
    for (int r = 0; r < 3; r++) begin
      rd_words[r] = rnd_d();
      mem_rd_valid = 1; mem_rd_data = rd_words[r];
      cycle();
      check($sformatf("route_sel%0d", r), {vga_rd_valid, hdr_rd_valid}, (r == 1) ? 2'b01 : 2'b10);
      check($sformatf("route_data%0d", r), (r == 1) ? hdr_rd_data : vga_rd_data, rd_words[r]);
      cycle();
    end

    // tag FIFO full
    do_reset(); mem_cmd_ready = 1;
    for (int r = 0; r < TD; r++) begin
      if (r % 2) begin hdr_rd_req = 1; hdr_rd_address = AW'(r); end
      else begin vga_rd_req = 1; vga_rd_address = AW'(r); end
      repeat (3) cycle();
    end
    vga_rd_req = 1; vga_rd_address = 25'h1234;
    hdr_wr_req = 1; hdr_wr_address = 25'h5678; hdr_wr_data = rnd_d();
    wr_seen = 0; rd_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (mem_cmd_valid && mem_cmd_we) wr_seen = 1;
      if (mem_cmd_valid && !mem_cmd_we) rd_seen = 1;
    end
    check("full_wr_issued", wr_seen, 1);
    check("full_rd_held", rd_seen, 0);
    check("full_vga_busy", vga_busy, 1);
    mem_rd_valid = 1; mem_rd_data = rnd_d();
    cycle();
    rd_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (mem_cmd_valid && !mem_cmd_we && mem_cmd_address == 25'h1234) rd_seen = 1;
    end
    check("full_rd_after_pop", rd_seen, 1);

    // errors and reset during ISSUE
    do_reset(); mem_cmd_ready = 0;
    hdr_rd_req = 1; hdr_rd_address = 25'h77; cycle();
    hdr_rd_req = 1; cycle();
    check("err_drop", arb_error[0], 1);
    do_reset();
    mem_rd_valid = 1; mem_rd_data = rnd_d(); cycle();
    check("err_orphan", arb_error[1], 1);
    cam_wr_req = 1; cam_wr_address = 25'h42; cycle(); cycle(); cycle();
    check("issue_hold", mem_cmd_valid, 1);
    rst_n = 0; cycle(); rst_n = 1;
    check("rst_valid", mem_cmd_valid, 0);
    check("rst_busy", {hdr_wr_busy, hdr_rd_busy, vga_busy, cam_busy}, 0);
    check("rst_err", arb_error, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      mem_cmd_ready = ($urandom_range(0, 9) < 7);
      cam_wr_req = ($urandom_range(0, 4) == 0); cam_wr_address = AW'($urandom); cam_wr_data = rnd_d();
      vga_rd_req = ($urandom_range(0, 4) == 0); vga_rd_address = AW'($urandom);
      hdr_rd_req = ($urandom_range(0, 4) == 0); hdr_rd_address = AW'($urandom);
      hdr_wr_req = ($urandom_range(0, 4) == 0); hdr_wr_address = AW'($urandom); hdr_wr_data = rnd_d();
      k = $urandom_range(0, 99);
      mem_rd_valid = (tagq.size() > 0) ? (k < 40) : (k == 0);
      mem_rd_data = rnd_d();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
